// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the round-robin ALU scheduler: opcode encoding, scheduler
// FSM state encoding and the default operand width.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SHL = 3'b010,
        ALU_SHR = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_EQ  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath.
// Ports:
//   a_i, b_i   [DATA_W]  operands
//   op_i       alu_op_e  opcode
//   result_o   [DATA_W]  result (add/sub wrap, shifts use b[2:0], eq is 0/1)
// -----------------------------------------------------------------------------
import alu_pkg::*;

module alu_core #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_SHL: result_o = a_i << b_i[2:0];
            ALU_SHR: result_o = a_i >> b_i[2:0];
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_EQ:  result_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_sched.sv
// -----------------------------------------------------------------------------
// alu_rr_sched
// Two-requester round-robin front end for a single shared ALU. One operation
// is in flight at a time: accept (IDLE) -> compute (EXEC) -> respond (RESP).
//
// State | meaning
// IDLE  | waiting for a request; ready asserted to the arbitration winner
// EXEC  | latched operands go through alu_core, result registered
// RESP  | result presented until rsp_valid_o & rsp_ready_i
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid_i/req_ready_o per-requester handshake (bit 0/1)
//   req{0,1}_{a,b,op}_i     operands and opcode of each requester
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_id_o, rsp_data_o    owning requester and result
//   grant_cnt{0,1}_o        saturating accept counters
//
// Build option: define ALU_RR_SCHED_STATS_EN to implement the grant counters;
// otherwise the counter ports read constant zero.
// -----------------------------------------------------------------------------
import alu_pkg::*;

module alu_rr_sched #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic [2:0]        req0_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    input  logic [2:0]        req1_op_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [CNT_W-1:0]  grant_cnt0_o,
    output logic [CNT_W-1:0]  grant_cnt1_o
);

    sched_state_e      state_q, state_d;
    logic              ptr_q;       // 1: requester 1 wins a tie
    logic              id_q;
    logic [DATA_W-1:0] a_q, b_q;
    alu_op_e           op_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] alu_res;

    logic any_valid;
    logic win_id;
    logic accept;

    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    always_comb begin
        any_valid = |req_valid_i;
        win_id    = req_valid_i[1] & (~req_valid_i[0] | ptr_q);
        accept    = (state_q == IDLE) && any_valid && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low during the reset cycle itself, not only after it.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE:    if (any_valid) req_ready_o[win_id] = 1'b1;
                RESP:    rsp_valid_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign rsp_id_o   = reset ? 1'b0 : id_q;
    assign rsp_data_o = reset ? '0 : rsp_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= 1'b0;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_ADD;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                id_q  <= win_id;
                a_q   <= win_id ? req1_a_i : req0_a_i;
                b_q   <= win_id ? req1_b_i : req0_b_i;
                op_q  <= alu_op_e'(win_id ? req1_op_i : req0_op_i);
                ptr_q <= ~win_id;
            end
            if (state_q == EXEC) rsp_data_q <= alu_res;
        end
    end

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_res)
    );

`ifdef ALU_RR_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (accept) begin
            if (!win_id && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
            if ( win_id && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign grant_cnt0_o = cnt0_q;
    assign grant_cnt1_o = cnt1_q;
`else
    assign grant_cnt0_o = '0;
    assign grant_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_sched
// Self-checking bench for alu_rr_sched: a transaction-level reference model
// checks every cycle, directed scenarios pin literal results.
// -----------------------------------------------------------------------------
module tb_alu_rr_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [7:0]  rsp_data;
    logic [15:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    alu_rr_sched dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req0_a_i     (a0),
        .req0_b_i     (b0),
        .req0_op_i    (op0),
        .req1_a_i     (a1),
        .req1_b_i     (b1),
        .req1_op_i    (op1),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .grant_cnt0_o (cnt0),
        .grant_cnt1_o (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input int a, input int b, input int op);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b + 256;
            2: r = a * (2 ** (b % 8));
            3: r = a / (2 ** (b % 8));
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = (a == b) ? 1 : 0;
        endcase
        return 8'(r % 256);
    endfunction

    // Transaction-level reference model: one op in flight, response two cycles
    // after acceptance, held until consumed; round-robin on ties.
    int       cyc = 0;
    bit       m_on = 0, m_busy = 0, m_ptr = 0;
    int       m_due = 0;
    bit       m_id;
    int       m_data;
    int       m_c0 = 0, m_c1 = 0;
    logic [8:0] log_q[$];

    always @(negedge clk) begin
        int w;
        cyc++;
        if (reset) begin
            check("rst_ready", req_ready, 0);
            check("rst_valid", rsp_valid, 0);
            check("rst_id", rsp_id, 0);
            check("rst_data", rsp_data, 0);
            m_on = 1; m_busy = 0; m_ptr = 0; m_c0 = 0; m_c1 = 0;
        end else if (m_on) begin
`ifdef ALU_RR_SCHED_STATS_EN
            check("m_cnt0", cnt0, m_c0);
            check("m_cnt1", cnt1, m_c1);
`else
            check("m_cnt0", cnt0, 0);
            check("m_cnt1", cnt1, 0);
`endif
            if (!m_busy) begin
                check("m_valid_idle", rsp_valid, 0);
                if (req_valid == 2'b00) begin
                    check("m_ready", req_ready, 0);
                end else begin
                    if (req_valid == 2'b11) w = m_ptr ? 1 : 0;
                    else                   w = req_valid[1] ? 1 : 0;
                    check("m_ready", req_ready, (w == 1) ? 2 : 1);
                    m_busy = 1;
                    m_due  = cyc + 2;
                    m_id   = (w == 1);
                    m_data = (w == 1) ? alu_ref(a1, b1, op1) : alu_ref(a0, b0, op0);
                    m_ptr  = (w == 0);
                    if (w == 1) m_c1 = (m_c1 < 65535) ? m_c1 + 1 : m_c1;
                    else        m_c0 = (m_c0 < 65535) ? m_c0 + 1 : m_c0;
                end
            end else if (cyc < m_due) begin
                check("m_ready_busy", req_ready, 0);
                check("m_valid_exec", rsp_valid, 0);
            end else begin
                check("m_ready_busy", req_ready, 0);
                check("m_valid_resp", rsp_valid, 1);
                check("m_id", rsp_id, m_id);
                check("m_data", rsp_data, m_data);
                if (rsp_ready) m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) log_q.push_back({rsp_id, rsp_data});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b00;
        tick(2);
        reset = 1'b0;
    endtask

    int base;

    initial begin
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
        tick(2);
        reset = 1'b0;

        // add, wrap, 2-cycle latency; operand change after accept is ignored
        req_valid = 2'b01; a0 = 8'h82; b0 = 8'hA6; op0 = 3'b000;
        @(negedge clk);
        check("t1_ready", req_ready, 2'b01);
        tick(1);
        req_valid = 2'b00; a0 = 8'h00;
        @(negedge clk);
        check("t1_not_yet", rsp_valid, 0);
        tick(1);
        @(negedge clk);
        check("t1_valid", rsp_valid, 1);
        check("t1_data", rsp_data, 8'h28);
        check("t1_id", rsp_id, 0);
        tick(1);

        // tie from reset: requester 0 first, then 1
        do_reset();
        base = log_q.size();
        req_valid = 2'b11;
        a0 = 8'h10; b0 = 8'h20; op0 = 3'b001;
        a1 = 8'h55; b1 = 8'h55; op1 = 3'b111;
        tick(6);
        req_valid = 2'b00;
        tick(2);
        check("t2_count", log_q.size() - base, 2);
        if (log_q.size() - base == 2) begin
            check("t2_first", log_q[base], {1'b0, 8'hF0});
            check("t2_second", log_q[base+1], {1'b1, 8'h01});
        end

        // continuous contention: ids alternate
        do_reset();
        base = log_q.size();
        req_valid = 2'b11;
        a0 = 8'h01; b0 = 8'h02; op0 = 3'b000;
        a1 = 8'hF0; b1 = 8'h0F; op1 = 3'b110;
        tick(12);
        req_valid = 2'b00;
        @(negedge clk);
`ifdef ALU_RR_SCHED_STATS_EN
        check("t3_cnt0", cnt0, 2);
        check("t3_cnt1", cnt1, 2);
`else
        check("t3_cnt0", cnt0, 0);
        check("t3_cnt1", cnt1, 0);
`endif
        tick(1);
        check("t3_count", log_q.size() - base, 4);
        if (log_q.size() - base == 4) begin
            check("t3_r0", log_q[base],   {1'b0, 8'h03});
            check("t3_r1", log_q[base+1], {1'b1, 8'hFF});
            check("t3_r2", log_q[base+2], {1'b0, 8'h03});
            check("t3_r3", log_q[base+3], {1'b1, 8'hFF});
        end

        // back-pressure in RESP: result stable, no new accept
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        a0 = 8'h0F; b0 = 8'h03; op0 = 3'b010;
        a1 = 8'h09; b1 = 8'h04; op1 = 3'b100;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_data", rsp_data, 8'h78);
            check("t4_no_ready", req_ready, 0);
            tick(1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_data", rsp_data, 8'h78);
        tick(1);
        @(negedge clk);
        check("t4_next_ready", req_ready, 2'b10);
        tick(1);
        req_valid = 2'b00;
        tick(3);

        // reset during EXEC discards the op; requester 0 wins afterwards
        do_reset();
        req_valid = 2'b01; a0 = 8'h11; b0 = 8'h22; op0 = 3'b000;
        tick(1);
        req_valid = 2'b00;
        reset = 1'b1;
        base = log_q.size();
        @(negedge clk);
        check("t5_rst_valid", rsp_valid, 0);
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_rsp", rsp_valid, 0);
        tick(1);
        req_valid = 2'b11; a0 = 8'h05;
        @(negedge clk);
        check("t5_win0", req_ready, 2'b01);
        tick(1);
        req_valid = 2'b00;
        tick(4);
        check("t5_count", log_q.size() - base, 1);
        if (log_q.size() - base == 1)
            check("t5_rsp", log_q[base], {1'b0, 8'h27});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
